// File: rtl/led_chaser_param.sv
// rtl/led_chaser_param.sv - parametrised single-LED chaser with dwell, direction and blink modes
module led_chaser_param #(
  parameter int N_LEDS  = 8,
  parameter int ON_CYC  = 300,
  parameter int OFF_CYC = 300,
  localparam int IW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led_out,
  output logic [IW-1:0]     idx,
  output logic              step,
  output logic              wrap
);

  localparam int MAXC = (ON_CYC > OFF_CYC) ? ((ON_CYC > 2) ? ON_CYC : 2)
                                           : ((OFF_CYC > 2) ? OFF_CYC : 2);
  localparam int CW = $clog2(MAXC);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'((OFF_CYC > 0) ? OFF_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST     = IW'(N_LEDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          dir;   // 1 = up
  logic          boundary;
  logic [IW-1:0] nxt_idx;
  logic [IW-1:0] start_idx;
  logic          nxt_dir;
  logic          nxt_wrap;

  function automatic logic [N_LEDS-1:0] led_vec(input logic [IW-1:0] i, input logic all_on);
    return all_on ? '1 : (N_LEDS'(1) << i);
  endfunction

  always_comb begin
    boundary  = en && (((state == S_ON) && (cnt == ON_LAST) && (OFF_CYC == 0)) ||
                       ((state == S_OFF) && (cnt == OFF_LAST)));
    start_idx = (mode == 2'b01) ? LAST : '0;
    nxt_idx   = idx;
    nxt_dir   = dir;
    nxt_wrap  = 1'b0;
    if (N_LEDS == 1) begin
      // A single LED never moves, but every non-blink boundary counts as a wrap.
      nxt_idx  = '0;
      nxt_wrap = (mode != 2'b11);
      if (mode == 2'b00) nxt_dir = 1'b1;
      if (mode == 2'b01) nxt_dir = 1'b0;
    end else begin
      case (mode)
        2'b00: begin
          nxt_dir = 1'b1;
          if (idx == LAST) begin
            nxt_idx  = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_idx = idx + 1'b1;
          end
        end
        2'b01: begin
          nxt_dir = 1'b0;
          if (idx == '0) begin
            nxt_idx  = LAST;
            nxt_wrap = 1'b1;
          end else begin
            nxt_idx = idx - 1'b1;
          end
        end
        2'b10: begin
          if (dir) begin
            if (idx == LAST) begin
              nxt_dir  = 1'b0;
              nxt_idx  = LAST - 1'b1;
              nxt_wrap = 1'b1;
            end else begin
              nxt_idx = idx + 1'b1;
            end
          end else begin
            if (idx == '0) begin
              nxt_dir  = 1'b1;
              nxt_idx  = IW'(1);
              nxt_wrap = 1'b1;
            end else begin
              nxt_idx = idx - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      dir     <= 1'b1;
      led_out <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (boundary) begin
        state   <= S_ON;
        cnt     <= '0;
        idx     <= nxt_idx;
        dir     <= nxt_dir;
        led_out <= led_vec(nxt_idx, mode == 2'b11);
        step    <= 1'b1;
        wrap    <= nxt_wrap;
      end else if (en) begin
        case (state)
          S_IDLE: begin
            state   <= S_ON;
            cnt     <= '0;
            idx     <= start_idx;
            led_out <= led_vec(start_idx, mode == 2'b11);
            step    <= 1'b1;
          end
          S_ON: begin
            if (cnt == ON_LAST) begin
              state   <= S_OFF;
              cnt     <= '0;
              led_out <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_OFF: cnt <= cnt + 1'b1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
